// File: rtl/regs2_if.sv
// rtl/regs2_if.sv - register-file access bundle between the ALU side and regs2
//
// Purpose: groups the read, write, flag and PC signals of the cpu2 register
// file so the core and the state block share one connection.
// Signals:
//   en          global clock enable for all state updates
//   rd_no       index driven on rd_val (ALU destination operand)
//   rb_no       index driven on rb_val (ALU second operand)
//   dbg_no      debug read index driven on dbg_val
//   rd_val      R[rd_no]
//   rb_val      R[rb_no]
//   dbg_val     R[dbg_no]
//   wr_en       general register write enable
//   wr_no       general register write index
//   wr_data     general register write data
//   flag_wr_en  flag register write enable
//   flag_in     next flag word
//   flags       current flag word
//   pc_inc      increment R15 by one
//   pc          current R15
// Modports: master drives the requests, slave is the register file.
interface regs2_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [3:0]       rd_no;
    logic [3:0]       rb_no;
    logic [3:0]       dbg_no;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] rb_val;
    logic [WIDTH-1:0] dbg_val;
    logic             wr_en;
    logic [3:0]       wr_no;
    logic [WIDTH-1:0] wr_data;
    logic             flag_wr_en;
    logic [WIDTH-1:0] flag_in;
    logic [WIDTH-1:0] flags;
    logic             pc_inc;
    logic [WIDTH-1:0] pc;

    modport master (
        output en, rd_no, rb_no, dbg_no, wr_en, wr_no, wr_data,
               flag_wr_en, flag_in, pc_inc,
        input  rd_val, rb_val, dbg_val, flags, pc
    );

    modport slave (
        input  en, rd_no, rb_no, dbg_no, wr_en, wr_no, wr_data,
               flag_wr_en, flag_in, pc_inc,
        output rd_val, rb_val, dbg_val, flags, pc
    );
endinterface

// File: rtl/regs2.sv
// rtl/regs2.sv - cpu2 architectural state: sixteen general registers and flags
//
// Purpose: holds R0..R15 (R15 is the program counter) and the flag word.
// Reads are combinational from stored state with no write bypass; writes,
// flag updates and PC increments commit on the rising clock edge when en=1.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset (overrides en and all writes)
//   bus    regs2_if slave modport carrying read/write/flag/PC signals
module regs2 #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic   clk,
    input  logic   reset,
    regs2_if.slave bus
);
    // Entry 15 is the PC, so every read port returns the PC for index 15
    // without any special-case muxing.
    logic [WIDTH-1:0] regs [0:15];
    logic [WIDTH-1:0] flag_q;

    // A jump (write to R15) takes precedence over the sequential increment.
    logic do_inc;
    assign do_inc = bus.pc_inc && !(bus.wr_en && (bus.wr_no == 4'd15));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
            regs[15] <= PC_RESET;
            flag_q   <= '0;
        end else if (bus.en) begin
            if (bus.wr_en) begin
                regs[bus.wr_no] <= bus.wr_data;
            end
            if (do_inc) begin
                regs[15] <= regs[15] + WIDTH'(1);
            end
            if (bus.flag_wr_en) begin
                flag_q <= bus.flag_in;
            end
        end
    end

    assign bus.rd_val  = regs[bus.rd_no];
    assign bus.rb_val  = regs[bus.rb_no];
    assign bus.dbg_val = regs[bus.dbg_no];
    assign bus.pc      = regs[15];
    assign bus.flags   = flag_q;
endmodule

// File: doc/regs2.md
# regs2

Architectural state block for the cpu2 core: sixteen WIDTH-bit general registers (R15 doubles as program counter) plus the flag register. It sits on both sides of the ALU. It supplies the destination-register value, second-operand register value and current flags. It commits the ALU result and flag word on the clock edge when the corresponding enables are set.

## Interface
- WIDTH, 32, register and data width
- PC_RESET, 0, value loaded into R15 at reset
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  global clock enable; when low, no register or flag state changes
- rd_no  input  4  index of register driven on rd_val (ALU destination operand)
- rb_no  input  4  index of register driven on rb_val (ALU second operand)
- rd_val  output  WIDTH  contents of R[rd_no]
- rb_val  output  WIDTH  contents of R[rb_no]
- wr_en  input  1  write enable for general register (ALU wb_en gated by condition)
- wr_no  input  4  register written when wr_en
- wr_data  input  WIDTH  data written (ALU res)
- flag_wr_en  input  1  flag register write enable (ALU flag_en gated by condition)
- flag_in  input  WIDTH  next flag word (ALU fo)
- flags  output  WIDTH  current flag register (to ALU fi)
- pc_inc  input  1  increment R15 by 1
- pc  output  WIDTH  current R15
- dbg_no  input  4  debug read index
- dbg_val  output  WIDTH  contents of R[dbg_no]

## Operation
- Reads are combinational and asynchronous from stored state. There is no write-through bypass. A value written at edge N is visible on rd_val/rb_val/dbg_val/pc after edge N.
- A read of index 15 on any read port returns the current PC.
- On a rising clk edge with reset=1: R0..R14 := 0, R15 := PC_RESET, flags := 0. This happens regardless of en.
- On a rising clk edge with reset=0 and en=0: all state is held.
- On a rising clk edge with reset=0 and en=1:
  - If wr_en is set, R[wr_no] := wr_data.
  - If flag_wr_en is set, flags := flag_in. All WIDTH bits are stored, including bits 8 and above.
  - R15 update priority:
    - wr_en with wr_no=15: R15 := wr_data, and pc_inc is ignored (jump wins).
    - otherwise, if pc_inc: R15 := R15 + 1, modulo 2^WIDTH (0xFFFFFFFF wraps to 0x00000000, with no carry out and no flag effect).
    - otherwise R15 is held.
- wr_en and flag_wr_en in the same cycle both take effect independently.
- A write to the same register that is being read in that cycle: the read returns the old value for that cycle.
- The flag register is written only through flag_wr_en. A general register write never alters flags.
- The block performs no arithmetic other than the PC increment.

## Timing
- Read latency: 0 cycles (combinational from rd_no/rb_no/dbg_no).
- Write latency: 1 edge. Data is visible in the cycle after the write.
- Reset values of outputs:
  - rd_val, rb_val, dbg_val = 0, except PC_RESET when the index is 15.
  - pc = PC_RESET.
  - flags = 0.
- Reset asserted mid-operation overrides any simultaneous wr_en, flag_wr_en or pc_inc on that edge.
- No multicycle paths. The ALU path into wr_data/flag_in must close in one cycle from rd_val/rb_val/flags.

## Test plan
- Reset with PC_RESET=0: assert reset for 1 edge while wr_en=1, wr_no=3, wr_data=0x55 -> R3=0, pc=0, flags=0 afterwards.
- Write/read: en=1, wr_en=1, wr_no=5, wr_data=0xDEADBEEF, rd_no=5 in the same cycle -> rd_val shows the old value (0) in that cycle, and 0xDEADBEEF after the edge. Then rb_no=5 and dbg_no=5 show the same value.
- PC increment and wrap: write R15=0xFFFFFFFE, then pc_inc=1 for 2 edges -> pc=0xFFFFFFFF, then 0x00000000.
- Jump priority: pc=0x100, pc_inc=1 and wr_en=1, wr_no=15, wr_data=0x2000 on the same edge -> pc=0x2000, not 0x2001.
- Flags:
  - flag_wr_en=1, flag_in=0x000000F3 -> flags=0x000000F3.
  - Next cycle flag_wr_en=0 with wr_en=1 to R2 -> flags unchanged at 0x000000F3.
- Enable hold: en=0 with wr_en=1, flag_wr_en=1, pc_inc=1 -> R[wr_no], flags and pc all unchanged. Raising en with the same inputs applies all three on the next edge.
